alu_regfile_dp: RTL
===================

Name: alu_regfile_dp

Overview:
Parametrised successor to the 8-bit ALU + register unit + flag unit datapath. It combines a generic-width ALU, an N-entry register file, a four-flag unit with a maskable jump output, and a load/store port with a memory handshake. It sits between the microsequencer, which drives the op fields, and the data memory. ALU ops complete in one cycle; memory ops stall the sequencer through op_ready.

Parameters:
DATA_W, 8, datapath and register width (>=4)
NREGS, 8, number of general registers (power of 2, >=2); RSEL_W = clog2(NREGS) is derived
ZERO_R0, 0, 1 = r0 reads as zero and writes to it are discarded

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
op_valid  in  1  microsequencer presents an op
op_ready  out  1  datapath can accept an op
op_kind  in  2  0 = ALU, 1 = LOAD, 2 = STORE, 3 = NOP
alu_op  in  4  ALU function (see Behaviour)
a_sel  in  RSEL_W  A-bus source register; also the memory address register
b_sel  in  RSEL_W  B-bus source register; also the store data register
c_sel  in  RSEL_W  destination register
c_en  in  1  enable write to the destination register
b_imm  in  1  1 = B bus takes imm instead of the register
imm  in  DATA_W  immediate operand
set_f  in  1  update flags on an ALU op
jam  in  3  jump mask, bits {C,N,Z}
j_out  out  1  jump condition
flags  out  4  stored {V,C,N,Z}
mem_req  out  1  memory request
mem_we  out  1  1 = write
mem_addr  out  DATA_W  memory address
mem_wdata  out  DATA_W  store data
mem_rdata  in  DATA_W  load data
mem_ack  in  1  memory completion, one cycle

Behaviour:
- One clock (clk). Reset is synchronous, active-low on rst_n. On reset, sampled at the clock edge: all registers = 0, flags = 0, state = IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0. op_ready is 1 after reset.
- A_BUS = reg[a_sel]. B_BUS = b_imm ? imm : reg[b_sel]. With ZERO_R0=1, reading r0 returns 0.
- An op is accepted when op_valid & op_ready.
- FSM states: IDLE, MEM_WAIT.
- IDLE:
  - op_ready = 1.
  - Accepted ALU op: at the same edge, reg[c_sel] <= result if c_en, and flags <= new flags if set_f. Stay in IDLE. Throughput is 1 op/cycle, and the result is readable on the next cycle.
  - Accepted NOP: no state change.
  - Accepted LOAD/STORE: register mem_addr = A_BUS, mem_wdata = B_BUS, mem_we = (op_kind==STORE), latch c_sel and c_en, set mem_req = 1, then go to MEM_WAIT.
- MEM_WAIT:
  - op_ready = 0, and mem_req, mem_addr, mem_wdata and mem_we are held.
  - On mem_ack: mem_req <= 0. For a LOAD with latched c_en, reg[latched c_sel] <= mem_rdata. Flags are unchanged. Return to IDLE, so op_ready is 1 on the next cycle.
  - There is no timeout.
  - mem_ack while in IDLE is ignored.
- Writes to r0 are discarded when ZERO_R0=1.
- ALU ops (A, B are DATA_W bits):
  - 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 NOT A, 6 PASS A, 7 PASS B
  - 8 INC A, 9 DEC A, 10 SHL A, 11 SHR A (logical), 12 ASR A, 13 ROL A, 14 ROR A, 15 PASS B
  - All results wrap modulo 2^DATA_W.
- Flags:
  - Z = (result==0).
  - N = result[DATA_W-1].
  - C:
    - ADD/INC: carry out.
    - SUB/DEC: borrow, i.e. 1 when A < subtrahend unsigned.
    - SHL/ROL: the old MSB.
    - SHR/ASR/ROR: the old LSB.
    - All other ops: 0.
  - V: two's-complement overflow for ADD/SUB/INC/DEC, otherwise 0.
- j_out = |(jam & {C,N,Z}) using the stored flags. It is combinational from the registers and jam, with no dependence on the current op.
- Simultaneous events:
  - If an ALU op with set_f is accepted, j_out reflects the new flags only from the next cycle.
  - If the same register is read and written in the same cycle, the read returns the old value (no bypass).
- Reset in MEM_WAIT: the FSM returns to IDLE and mem_req drops at that edge. A late mem_ack is then ignored.

Test Plan:
1. Reset, then ALU ADD with r1=0x7F (loaded via LOAD), b_imm=1, imm=0x01, c_sel=2, set_f=1 -> r2=0x80, flags V=1 C=0 N=1 Z=0.
2. SUB with r1=0x05, imm=0x05, set_f=1, jam=3'b001 -> r=0x00, Z=1, C=0; j_out=1 from the next cycle. Repeat with jam=3'b100 -> j_out=0.
3. LOAD a_sel=r3 (=0x40), c_sel=4; hold mem_ack low for 3 cycles, then pulse it with mem_rdata=0xA5 -> mem_req=1 and mem_addr=0x40 for 4 cycles, op_ready=0 throughout, r4=0xA5 afterwards, flags unchanged.
4. STORE b_sel=r4 -> mem_we=1, mem_wdata=0xA5. Drop rst_n low while in MEM_WAIT -> next cycle mem_req=0, op_ready=1, all registers 0.
5. Back-to-back ALU ops on consecutive cycles (INC r1 then PASS A r1 -> r2) -> r2 holds the incremented value with no stall. With ZERO_R0=1, a write to r0 leaves it reading 0.
6. DATA_W=16, NREGS=16: ROR of 0x0001 -> 0x8000 with C=1. DEC of 0x0000 -> 0xFFFF with C=1, N=1.

Source files
------------

// File: rtl/alu_regfile_dp.sv
// rtl/alu_regfile_dp.sv - parametrised ALU + register file + flag unit datapath with load/store port
module alu_regfile_dp #(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 8,
  parameter int ZERO_R0 = 0,
  localparam int RSEL_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_kind,
  input  logic [3:0]        alu_op,
  input  logic [RSEL_W-1:0] a_sel,
  input  logic [RSEL_W-1:0] b_sel,
  input  logic [RSEL_W-1:0] c_sel,
  input  logic              c_en,
  input  logic              b_imm,
  input  logic [DATA_W-1:0] imm,
  input  logic              set_f,
  input  logic [2:0]        jam,
  output logic              j_out,
  output logic [3:0]        flags,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam logic [1:0] K_ALU   = 2'd0;
  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;
  localparam int         M       = DATA_W - 1;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t              state;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [RSEL_W-1:0]   lat_c;
  logic                lat_load_en;

  logic [DATA_W-1:0]   a_bus, b_bus, opnd, res;
  logic [DATA_W:0]     sum;
  logic                c_new, v_new;

  assign a_bus = (ZERO_R0 != 0 && a_sel == '0) ? '0 : regs[a_sel];
  assign b_bus = b_imm ? imm : ((ZERO_R0 != 0 && b_sel == '0) ? '0 : regs[b_sel]);
  // INC/DEC share the adder/subtractor with a constant-one operand
  assign opnd  = (alu_op == 4'd8 || alu_op == 4'd9) ? ONE : b_bus;
  assign j_out = |(jam & flags[2:0]);

  always_comb begin
    res   = '0;
    sum   = '0;
    c_new = 1'b0;
    v_new = 1'b0;
    case (alu_op)
      4'd0, 4'd8: begin
        sum   = {1'b0, a_bus} + {1'b0, opnd};
        res   = sum[DATA_W-1:0];
        c_new = sum[DATA_W];
        v_new = (a_bus[M] == opnd[M]) && (res[M] != a_bus[M]);
      end
      4'd1, 4'd9: begin
        sum   = {1'b0, a_bus} - {1'b0, opnd};
        res   = sum[DATA_W-1:0];
        c_new = sum[DATA_W];
        v_new = (a_bus[M] != opnd[M]) && (res[M] != a_bus[M]);
      end
      4'd2: res = a_bus & b_bus;
      4'd3: res = a_bus | b_bus;
      4'd4: res = a_bus ^ b_bus;
      4'd5: res = ~a_bus;
      4'd6: res = a_bus;
      4'd7, 4'd15: res = b_bus;
      4'd10: begin res = {a_bus[M-1:0], 1'b0};      c_new = a_bus[M]; end
      4'd11: begin res = {1'b0, a_bus[M:1]};        c_new = a_bus[0]; end
      4'd12: begin res = {a_bus[M], a_bus[M:1]};    c_new = a_bus[0]; end
      4'd13: begin res = {a_bus[M-1:0], a_bus[M]};  c_new = a_bus[M]; end
      4'd14: begin res = {a_bus[0], a_bus[M:1]};    c_new = a_bus[0]; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      flags       <= '0;
      state       <= IDLE;
      op_ready    <= 1'b1;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      lat_c       <= '0;
      lat_load_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            if (op_kind == K_ALU) begin
              if (c_en && !(ZERO_R0 != 0 && c_sel == '0)) regs[c_sel] <= res;
              if (set_f) flags <= {v_new, c_new, res[M], res == '0};
            end else if (op_kind == K_LOAD || op_kind == K_STORE) begin
              mem_addr    <= a_bus;
              mem_wdata   <= b_bus;
              mem_we      <= (op_kind == K_STORE);
              lat_c       <= c_sel;
              lat_load_en <= c_en && (op_kind == K_LOAD);
              mem_req     <= 1'b1;
              op_ready    <= 1'b0;
              state       <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            if (lat_load_en && !(ZERO_R0 != 0 && lat_c == '0)) regs[lat_c] <= mem_rdata;
            mem_req  <= 1'b0;
            op_ready <= 1'b1;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
